// File: rtl/instr_mem_if.sv
// Fetch/program-load bus between the PC/loader side (master) and instr_mem_ctrl (slave).
// parity_err exists only when IMEM_PARITY_EN is defined.
`timescale 1ns/1ps
interface instr_mem_if #(
  parameter int DATA_W = 8,
  parameter int PC_W   = 8
) ();
  logic [PC_W-1:0]   pc;
  logic              fetch_en;
  logic [DATA_W-1:0] instruction;
  logic              instr_valid;
  logic              addr_err;
  logic              wr_en;
  logic [PC_W-1:0]   wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              busy;
`ifdef IMEM_PARITY_EN
  logic              parity_err;
`endif

  modport master (
    output pc, fetch_en, wr_en, wr_addr, wr_data,
`ifdef IMEM_PARITY_EN
    input  parity_err,
`endif
    input  instruction, instr_valid, addr_err, busy
  );

  modport slave (
    input  pc, fetch_en, wr_en, wr_addr, wr_data,
`ifdef IMEM_PARITY_EN
    output parity_err,
`endif
    output instruction, instr_valid, addr_err, busy
  );
endinterface

// File: rtl/instr_mem_ctrl.sv
// Writable instruction memory with registered fetch, post-reset clear sequencer and
// out-of-range detection. Optional per-word even parity: define IMEM_PARITY_EN.
`timescale 1ns/1ps
module instr_mem_ctrl #(
  parameter int                DATA_W   = 8,
  parameter int                PC_W     = 8,
  parameter int                DEPTH    = 16,
  parameter logic [DATA_W-1:0] NOP_WORD = '0
) (
  input  logic       clk,
  input  logic       rst_n,
  instr_mem_if.slave bus
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
`ifdef IMEM_PARITY_EN
  localparam int MEM_W = DATA_W + 1;
`else
  localparam int MEM_W = DATA_W;
`endif
  // DEPTH may equal 2**PC_W, so the bound needs one bit more than pc.
  localparam logic [PC_W:0]    DEPTH_CMP = (PC_W + 1)'(DEPTH);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DEPTH - 1);

  localparam logic [0:0] S_CLEAR = 1'b0;
  localparam logic [0:0] S_READY = 1'b1;

  logic [MEM_W-1:0] mem [DEPTH];

  logic [0:0]        state_q, state_d;
  logic [IDX_W-1:0]  clr_cnt_q, clr_cnt_d;
  logic [DATA_W-1:0] instruction_q, instruction_d;
  logic              instr_valid_q, instr_valid_d;
  logic              addr_err_q, addr_err_d;
`ifdef IMEM_PARITY_EN
  logic              parity_err_q, parity_err_d;
`endif

  logic              mem_we;
  logic [IDX_W-1:0]  mem_waddr;
  logic [MEM_W-1:0]  mem_wdata;
  logic [MEM_W-1:0]  rd_word;
  logic              pc_ok;
  logic              wr_ok;

  function automatic logic [MEM_W-1:0] encode_word(input logic [DATA_W-1:0] w);
`ifdef IMEM_PARITY_EN
    return {^w, w};
`else
    return w;
`endif
  endfunction

  // Full-width compares: high pc bits never alias onto a valid entry.
  assign pc_ok   = {1'b0, bus.pc} < DEPTH_CMP;
  assign wr_ok   = {1'b0, bus.wr_addr} < DEPTH_CMP;
  assign rd_word = mem[bus.pc[IDX_W-1:0]];

  always_comb begin
    state_d       = state_q;
    clr_cnt_d     = clr_cnt_q;
    instruction_d = instruction_q;
    instr_valid_d = 1'b0;
    addr_err_d    = 1'b0;
`ifdef IMEM_PARITY_EN
    parity_err_d  = 1'b0;
`endif
    mem_we        = 1'b0;
    mem_waddr     = clr_cnt_q;
    mem_wdata     = encode_word(NOP_WORD);

    case (state_q)
      S_CLEAR: begin
        mem_we    = 1'b1;
        clr_cnt_d = clr_cnt_q + 1'b1;
        if (clr_cnt_q == LAST_IDX) begin
          state_d = S_READY;
        end
      end
      default: begin
        if (bus.fetch_en) begin
          instr_valid_d = 1'b1;
          if (pc_ok) begin
            instruction_d = rd_word[DATA_W-1:0];
`ifdef IMEM_PARITY_EN
            parity_err_d  = ^rd_word;
`endif
          end else begin
            instruction_d = NOP_WORD;
            addr_err_d    = 1'b1;
          end
        end
        if (bus.wr_en && wr_ok) begin
          mem_we    = 1'b1;
          mem_waddr = bus.wr_addr[IDX_W-1:0];
          mem_wdata = encode_word(bus.wr_data);
        end
      end
    endcase
  end

  // ---- fetch stage / control registers ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_CLEAR;
      clr_cnt_q     <= '0;
      instruction_q <= '0;
      instr_valid_q <= 1'b0;
      addr_err_q    <= 1'b0;
`ifdef IMEM_PARITY_EN
      parity_err_q  <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      clr_cnt_q     <= clr_cnt_d;
      instruction_q <= instruction_d;
      instr_valid_q <= instr_valid_d;
      addr_err_q    <= addr_err_d;
`ifdef IMEM_PARITY_EN
      parity_err_q  <= parity_err_d;
`endif
    end
  end

  // Storage is never reset; the clear sequencer initialises it. The read above sees the
  // pre-edge contents, which gives read-before-write on a same-address fetch+write.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  assign bus.instruction = instruction_q;
  assign bus.instr_valid = instr_valid_q;
  assign bus.addr_err    = addr_err_q;
  assign bus.busy        = (state_q == S_CLEAR);
`ifdef IMEM_PARITY_EN
  assign bus.parity_err  = parity_err_q;
`endif

endmodule
